mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The port list SHALL be, clock and reset first:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request new operation; sampled only in IDLE
- op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
- operand_a  input  32  multiplicand / dividend, driven from register file read_data1
- operand_b  input  32  multiplier / divisor, driven from register file read_data2
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- hi  output  32  product[63:32] or remainder
- lo  output  32  product[31:0] or quotient
- div_by_zero  output  1  last completed divide had operand_b == 0
REQ-003 The block SHALL have no parameters; the datapath is 32 bits wide.

Function
REQ-004 The FSM SHALL have three states: IDLE, CALC, FINISH.
REQ-005 In IDLE, on the edge where start=1 (edge 0), the block SHALL:
- latch op, operand_a and operand_b
- take magnitudes of the operands for signed ops
- clear the 6-bit iteration counter
- go to CALC and set busy=1
REQ-006 CALC SHALL process one bit per edge for exactly 32 edges (edges 1..32):
- multiply: shift-add
- divide: restoring
- at edge 32 go to FINISH
REQ-007 At edge 33 FINISH SHALL:
- apply sign correction
- load hi and lo
- set done=1 and busy=0
- update div_by_zero
- return to IDLE
REQ-008 done SHALL be high for exactly one cycle (edge 33 to edge 34); start-to-done latency is fixed at 33 edges for all ops, including divide by zero.
REQ-009 start SHALL be ignored while busy=1; latched operands SHALL NOT change mid-operation.
REQ-010 start asserted in the same cycle that done=1 SHALL be accepted, since the FSM is in IDLE that cycle.
REQ-011 mult SHALL produce the 64-bit two's-complement product; multu SHALL produce the 64-bit unsigned product.
REQ-012 div signed results SHALL follow:
- quotient sign = sign(a) XOR sign(b)
- remainder sign = sign(a)
- quotient truncates toward zero
REQ-013 div 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no trap.
REQ-014 Divide with operand_b=0 SHALL give:
- div_by_zero=1
- hi = operand_a as latched
- lo = 0xFFFFFFFF
REQ-015 A multiply SHALL clear div_by_zero at FINISH; a non-zero divide SHALL also clear it.
REQ-016 hi, lo and div_by_zero SHALL hold their values between operations; they change only at FINISH.
REQ-017 All 32-bit arithmetic SHALL wrap modulo 2^32 on negation; no internal state SHALL be observable on outputs before FINISH.

Reset
REQ-018 While reset_n=0, asynchronously:
- state=IDLE
- busy=0, done=0, div_by_zero=0
- hi=0, lo=0
- counter and operand registers cleared
REQ-019 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow after release.
REQ-020 After reset_n rises, the first start SHALL be accepted on the next rising edge.

Verification
REQ-021 op=01, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done pulses exactly 33 edges after start edge, busy high for 33 cycles.
REQ-022 op=00, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-023 op=10, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; op=10, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-024 op=11, a=0x64, b=0 -> div_by_zero=1, hi=0x64, lo=0xFFFFFFFF; then op=01, a=2, b=3 -> div_by_zero=0, lo=6, hi=0.
REQ-025 start op=01 a=2 b=3, then start re-pulsed at edge 5 with a=7 b=7 -> ignored, lo=6; start held in the done cycle with a=7 b=7 -> second op accepted, lo=0x31 33 edges later.
REQ-026 reset_n driven low at edge 10 of an operation -> busy, done, hi, lo go to 0 immediately; no done within 40 cycles after release without a new start.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit.
// Handles signed and unsigned multiply (shift-add) and divide (restoring).
// Every operation takes 33 edges from accept to done.
// Results appear on hi/lo only at FINISH and are held until the next FINISH.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        is_div;
  logic        sa_reg, sb_reg;
  logic [31:0] a_reg, b_reg;
  logic [31:0] m_reg;     // multiplicand magnitude (mult) or divisor magnitude (div)
  logic [31:0] acc_hi, acc_lo;

  // Two's-complement negation, wraps modulo 2^32
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a value whose sign bit is only meaningful for signed ops
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return sgn ? neg32(v) : v;
  endfunction

  logic        signed_op, sa_in, sb_in;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod, prod_res;
  logic [31:0] quo_res, rem_res;

  assign signed_op = ~op[0];
  assign sa_in     = signed_op & operand_a[31];
  assign sb_in     = signed_op & operand_b[31];
  assign mag_a     = mag32(operand_a, sa_in);
  assign mag_b     = mag32(operand_b, sb_in);

  assign mul_sum   = {1'b0, acc_hi} + {1'b0, m_reg};
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_diff  = div_shift - {1'b0, m_reg};

  assign prod      = {acc_hi, acc_lo};
  assign prod_res  = (sa_reg ^ sb_reg) ? (~prod + 64'd1) : prod;
  assign quo_res   = (sa_reg ^ sb_reg) ? neg32(acc_lo) : acc_lo;
  assign rem_res   = sa_reg ? neg32(acc_hi) : acc_hi;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: accept start only in IDLE, leave CALC after 32 steps
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 6'd31) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch and one-bit-per-edge iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      sa_reg <= 1'b0;
      sb_reg <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= '0;
          is_div <= op[1];
          sa_reg <= sa_in;
          sb_reg <= sb_in;
          a_reg  <= operand_a;
          b_reg  <= operand_b;
          m_reg  <= op[1] ? mag_b : mag_a;
          acc_hi <= '0;
          acc_lo <= op[1] ? mag_a : mag_b;
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (!is_div) begin
            {acc_hi, acc_lo} <= acc_lo[0] ? {mul_sum, acc_lo[31:1]}
                                          : {1'b0, acc_hi, acc_lo[31:1]};
          end else begin
            acc_hi <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
            acc_lo <= {acc_lo[30:0], ~div_diff[32]};
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs and result registers; results load only at FINISH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) busy <= 1'b1;
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!is_div) begin
            hi          <= prod_res[63:32];
            lo          <= prod_res[31:0];
            div_by_zero <= 1'b0;
          end else if (b_reg == 32'd0) begin
            hi          <= a_reg;
            lo          <= 32'hFFFF_FFFF;
            div_by_zero <= 1'b1;
          end else begin
            hi          <= rem_res;
            lo          <= quo_res;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge (edge 0); returns after edge 0 with start low
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    tick();
    start = 1'b0;
  endtask

  // Wait for done; lat counts edges since edge 0, bsy counts busy samples after edge 0
  task automatic wait_done(input int already, output int lat, output int bsy);
    lat = already;
    bsy = busy ? 1 : 0;
    while (lat < 60) begin
      tick();
      lat++;
      if (done) break;
      if (busy) bsy++;
    end
    if (!done) lat = -1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    int lat, bsy;
    issue(o, a, b);
    wait_done(0, lat, bsy);
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check({tag, " dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
  endtask

  initial begin
    int lat, bsy, dcnt;

    // Reset
    #2 reset_n = 1'b0;
    tick(); tick();
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst hi", {32'd0, hi}, 64'd0);
    check("rst lo", {32'd0, lo}, 64'd0);
    check("rst dbz", {63'd0, div_by_zero}, 64'd0);
    reset_n = 1'b1;

    // multu max*max with busy length and pulse width
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu busy after start", {63'd0, busy}, 64'd1);
    wait_done(0, lat, bsy);
    check("multu latency", 64'(lat), 64'd33);
    check("multu busy cycles", 64'(bsy), 64'd33);
    check("multu busy at done", {63'd0, busy}, 64'd0);
    check("multu hi", {32'd0, hi}, 64'hFFFF_FFFE);
    check("multu lo", {32'd0, lo}, 64'h1);
    tick();
    check("done one cycle", {63'd0, done}, 64'd0);

    run_op("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu by zero", 2'b11, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1);
    run_op("div by zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run_op("multu 2*3", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    // Results hold while idle
    repeat (5) tick();
    check("hold lo", {32'd0, lo}, 64'd6);
    check("hold dbz", {63'd0, div_by_zero}, 64'd0);

    // Start re-pulsed mid-operation is ignored; outputs unchanged before FINISH
    operand_a = 32'd0;
    issue(2'b01, 32'd2, 32'd3);
    repeat (4) tick();
    start = 1'b1; operand_a = 32'd7; operand_b = 32'd7;
    tick();
    start = 1'b0;
    check("repulse busy", {63'd0, busy}, 64'd1);
    check("repulse hi held", {32'd0, hi}, 64'd0);
    wait_done(5, lat, bsy);
    check("repulse latency", 64'(lat), 64'd33);
    check("repulse lo", {32'd0, lo}, 64'd6);

    // Start in the done cycle is accepted
    start = 1'b1; op = 2'b01; operand_a = 32'd7; operand_b = 32'd7;
    tick();
    start = 1'b0;
    check("back2back done low", {63'd0, done}, 64'd0);
    check("back2back busy", {63'd0, busy}, 64'd1);
    wait_done(0, lat, bsy);
    check("back2back latency", 64'(lat), 64'd33);
    check("back2back lo", {32'd0, lo}, 64'h31);
    check("back2back hi", {32'd0, hi}, 64'd0);

    // Reset mid-operation aborts it
    issue(2'b00, 32'd5, 32'd6);
    repeat (9) tick();
    check("pre-abort busy", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort hi", {32'd0, hi}, 64'd0);
    check("abort lo", {32'd0, lo}, 64'd0);
    tick();
    reset_n = 1'b1;
    dcnt = 0;
    bsy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcnt++;
      if (busy) bsy++;
    end
    check("no done after abort", 64'(dcnt), 64'd0);
    check("no busy after abort", 64'(bsy), 64'd0);

    run_op("post-reset mult", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
